bids22_host_seq: RTL and testbench
==================================

// Module: bids22_host_seq
// PURPOSE
//  Host-side initiator for the bids22 auction-controller control interface (C_op/C_data/C_start; cout ready/err/maxBid).
//  Accepts one auction job over valid/ready, then drives the control interface: unlock, load X/Y/Z, mask, timer, charge, lock, run round.
//  After the round it reports maxBid or the first controller error code.
//  Sits between a testbench/CPU job source and the bids22 controller.
// PARAMETERS
//  DATAWIDTH   32  width of C_data, balances, key, maxBid
//  NUMBIDDERS  3   mask width (only 3 supported by the controller)
//  RLENW       8   width of round_len (cycles C_start is held high)
//  WDT_CYCLES  64  decision-wait timeout in cycles; used only with BIDS22_HOST_WATCHDOG_EN
// PORTS
//  clk            in   1           clock, all state on posedge
//  reset          in   1           asynchronous, active-high reset
//  job_valid      in   1           job offered
//  job_ready      out  1           job accepted when valid&ready
//  job_bal        in   3*DATAWIDTH X=[DW-1:0], Y next, Z top
//  job_mask       in   NUMBIDDERS  bidder enable mask
//  job_timer      in   DATAWIDTH   cooldown timer value
//  job_charge     in   DATAWIDTH   per-bid charge
//  job_key        in   DATAWIDTH   lock key
//  job_rlen       in   RLENW       round length; 0 treated as 1
//  C_op           out  OPW         opcode to controller (package enum)
//  C_data         out  DATAWIDTH   operand to controller
//  C_start        out  1           round active
//  cout_ready     in   1           controller ready (low in decision cycle)
//  cout_err       in   ERRW        controller error (package enum, NOERROR=0)
//  cout_maxBid    in   DATAWIDTH   controller max bid
//  done           out  1           1-cycle pulse: job finished
//  res_maxbid     out  DATAWIDTH   captured maxBid, held until next done
//  res_err        out  ERRW        0 = ok, else first cout_err seen / TIMEOUT code
//  busy           out  1           job in flight
// BEHAVIOUR
//  Reset: C_op=NO_OP, C_data=0, C_start=0, job_ready=0 for 1 cycle then 1, done=0, res_*=0, busy=0, locked flag=0.
//  Job fields registered on accept; job_ready=0 while busy. Inputs changing mid-job are ignored.
//  FSM: IDLE -> [UNLK if locked] -> LDX -> LDY -> LDZ -> MASK -> TMR -> CHG -> LOCK -> START -> DECIDE -> DRAIN -> REPORT -> IDLE.
//  Each op state: drive C_op/C_data for exactly 1 cycle, only when cout_ready=1, else stall. Then 1 CHECK cycle with C_op=NO_OP sampling cout_err.
//  UNLK uses the key of the previous job (stored); C_data=job_key on LOCK, after which the locked flag is set.
//  cout_err!=0 in any CHECK cycle -> REPORT with res_err=that code; remaining ops skipped.
//  On BADKEY after UNLK the locked flag stays 1 and C_start is never raised.
//  START: C_start=1 for max(job_rlen,1) cycles (down-counter), C_op=NO_OP.
//  DECIDE: C_start=0; wait for cout_ready=0; capture res_maxbid=cout_maxBid in that cycle.
//  DRAIN: wait for cout_ready=1.
//  REPORT: done=1 for 1 cycle, busy drops the same cycle, job_ready=1 next cycle.
//  Back-to-back jobs: accept in IDLE the cycle after REPORT (min 1 idle cycle).
//  Reset mid-job: immediate abort, all outputs to reset values, locked flag cleared (controller also resets).
// CONFIGURATION
//  BIDS22_HOST_WATCHDOG_EN defined: DECIDE+DRAIN bounded by WDT_CYCLES.
//    On expiry -> REPORT with res_err=HOST_TIMEOUT (package const, ERRW all-ones) and res_maxbid=0.
//  Undefined: DECIDE/DRAIN wait indefinitely; no counter logic is synthesised.
// STRUCTURE
//  bids22defs package: opcode enum (NO_OP=0,UNLOCK,LOCK,LOADX,LOADY,LOADZ,SETMASK,SETTIMER,SETBIDCHARGE=8) and OPW=4.
//  Package also holds the cout error enum, ERRW=4, HOST_TIMEOUT and the host FSM state typedef.
//  Single module; no sub-module (round/watchdog counters inline).
// TESTING
//  1 First job after reset, bal X/Y/Z=100/200/300, mask=3'b111, timer=15, charge=1, key=0xA5, rlen=4:
//    -> ops LOADX..LOCK in order with no UNLOCK; C_start high 4 cycles; done with res_err=0.
//  2 Controller model returns maxBid=42 during the ready=0 cycle -> res_maxbid=42 at done.
//  3 Second job key=0x5A: UNLOCK issued with C_data=0xA5 first; model answers BADKEY
//    -> res_err=BADKEY, no LOADX issued, C_start never high, busy drops.
//  4 cout_ready held low 3 cycles before LOADY -> LOADY issued once, on the first cycle ready=1; no duplicate op.
//  5 rlen=0 -> C_start high exactly 1 cycle.
//  6 reset asserted during START -> same cycle C_start=0 and busy=0; next job issues no UNLOCK.
//  7 With BIDS22_HOST_WATCHDOG_EN and WDT_CYCLES=8, ready never drops -> done after 8 DECIDE cycles, res_err=HOST_TIMEOUT.

Source files
------------

// File: rtl/bids22_host_seq_pkg.sv
// Shared definitions for the bids22 host sequencer: controller opcodes, error codes,
// host FSM states and the op-state helpers used to walk the configuration sequence.
package bids22defs;

  localparam int OPW  = 4;
  localparam int ERRW = 4;

  typedef enum logic [OPW-1:0] {
    NO_OP        = 4'd0,
    UNLOCK       = 4'd1,
    LOCK         = 4'd2,
    LOADX        = 4'd3,
    LOADY        = 4'd4,
    LOADZ        = 4'd5,
    SETMASK      = 4'd6,
    SETTIMER     = 4'd7,
    SETBIDCHARGE = 4'd8
  } op_e;

  typedef enum logic [ERRW-1:0] {
    NOERROR      = 4'd0,
    ERR_LOCKED   = 4'd1,
    BADKEY       = 4'd2,
    ERR_UNLOCKED = 4'd3,
    BADMASK      = 4'd4
  } err_e;

  localparam logic [ERRW-1:0] HOST_TIMEOUT = 4'hF;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_UNLK   = 4'd1,
    S_LDX    = 4'd2,
    S_LDY    = 4'd3,
    S_LDZ    = 4'd4,
    S_MASK   = 4'd5,
    S_TMR    = 4'd6,
    S_CHG    = 4'd7,
    S_LOCK   = 4'd8,
    S_CHECK  = 4'd9,
    S_START  = 4'd10,
    S_DECIDE = 4'd11,
    S_DRAIN  = 4'd12,
    S_REPORT = 4'd13
  } host_state_e;

  // Successor of an op state once its CHECK cycle has seen no error.
  function automatic host_state_e after_check(input host_state_e s);
    case (s)
      S_UNLK:  after_check = S_LDX;
      S_LDX:   after_check = S_LDY;
      S_LDY:   after_check = S_LDZ;
      S_LDZ:   after_check = S_MASK;
      S_MASK:  after_check = S_TMR;
      S_TMR:   after_check = S_CHG;
      S_CHG:   after_check = S_LOCK;
      S_LOCK:  after_check = S_START;
      default: after_check = S_REPORT;
    endcase
  endfunction

  function automatic op_e state_op(input host_state_e s);
    case (s)
      S_UNLK:  state_op = UNLOCK;
      S_LDX:   state_op = LOADX;
      S_LDY:   state_op = LOADY;
      S_LDZ:   state_op = LOADZ;
      S_MASK:  state_op = SETMASK;
      S_TMR:   state_op = SETTIMER;
      S_CHG:   state_op = SETBIDCHARGE;
      S_LOCK:  state_op = LOCK;
      default: state_op = NO_OP;
    endcase
  endfunction

endpackage

// File: rtl/bids22_host_seq_if.sv
// Job, controller and result signals of the bids22 host sequencer.
// master = sequencer side, slave = job source / controller side.
interface bids22_host_seq_if #(
  parameter int DATAWIDTH  = 32,
  parameter int NUMBIDDERS = 3,
  parameter int RLENW      = 8
);
  import bids22defs::*;

  logic                   job_valid;
  logic                   job_ready;
  logic [3*DATAWIDTH-1:0] job_bal;
  logic [NUMBIDDERS-1:0]  job_mask;
  logic [DATAWIDTH-1:0]   job_timer;
  logic [DATAWIDTH-1:0]   job_charge;
  logic [DATAWIDTH-1:0]   job_key;
  logic [RLENW-1:0]       job_rlen;
  logic [OPW-1:0]         C_op;
  logic [DATAWIDTH-1:0]   C_data;
  logic                   C_start;
  logic                   cout_ready;
  logic [ERRW-1:0]        cout_err;
  logic [DATAWIDTH-1:0]   cout_maxBid;
  logic                   done;
  logic [DATAWIDTH-1:0]   res_maxbid;
  logic [ERRW-1:0]        res_err;
  logic                   busy;

  modport master (
    input  job_valid, job_bal, job_mask, job_timer, job_charge, job_key, job_rlen,
    input  cout_ready, cout_err, cout_maxBid,
    output job_ready, C_op, C_data, C_start, done, res_maxbid, res_err, busy
  );

  modport slave (
    output job_valid, job_bal, job_mask, job_timer, job_charge, job_key, job_rlen,
    output cout_ready, cout_err, cout_maxBid,
    input  job_ready, C_op, C_data, C_start, done, res_maxbid, res_err, busy
  );
endinterface

// File: rtl/bids22_host_seq.sv
// Host-side initiator for the bids22 auction controller: takes one job, programs and runs a round.
// Optional decision watchdog: define BIDS22_HOST_WATCHDOG_EN.
module bids22_host_seq
  import bids22defs::*;
#(
  parameter int DATAWIDTH  = 32,
  parameter int NUMBIDDERS = 3,
  parameter int RLENW      = 8,
  parameter int WDT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  bids22_host_seq_if.master bus
);

  host_state_e            r_state, w_state_n, r_op_st;
  logic [3*DATAWIDTH-1:0] r_bal;
  logic [NUMBIDDERS-1:0]  r_mask;
  logic [DATAWIDTH-1:0]   r_timer, r_charge, r_key, r_lock_key;
  logic [RLENW-1:0]       r_rlen, r_rcnt;
  logic                   r_locked, r_armed, w_accept;
  logic [ERRW-1:0]        r_err, w_err_n, r_res_err;
  logic [DATAWIDTH-1:0]   r_bid, w_bid_n, r_res_bid, w_data;
  op_e                    w_op;

`ifdef BIDS22_HOST_WATCHDOG_EN
  localparam int WDTW = $clog2(WDT_CYCLES + 1);
  logic [WDTW-1:0] r_wdt;

  // Decision watchdog: counts cycles spent waiting in DECIDE and DRAIN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdt <= '0;
    end else if (r_state == S_DECIDE || r_state == S_DRAIN) begin
      r_wdt <= r_wdt + WDTW'(1);
    end else begin
      r_wdt <= '0;
    end
  end
`endif

  assign w_accept = (r_state == S_IDLE) && r_armed && bus.job_valid;

  // Next state, controller op/data and result bookkeeping.
  always_comb begin
    w_state_n = r_state;
    w_op      = NO_OP;
    w_data    = '0;
    w_err_n   = r_err;
    w_bid_n   = r_bid;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_n = r_locked ? S_UNLK : S_LDX;
          w_err_n   = '0;
          w_bid_n   = '0;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_UNLK, S_LDX, S_LDY, S_LDZ, S_MASK, S_TMR, S_CHG, S_LOCK: begin
        case (r_state)
          S_UNLK:  w_data = r_lock_key;
          S_LDX:   w_data = r_bal[DATAWIDTH-1:0];
          S_LDY:   w_data = r_bal[2*DATAWIDTH-1:DATAWIDTH];
          S_LDZ:   w_data = r_bal[3*DATAWIDTH-1:2*DATAWIDTH];
          S_MASK:  w_data[NUMBIDDERS-1:0] = r_mask;
          S_TMR:   w_data = r_timer;
          S_CHG:   w_data = r_charge;
          S_LOCK:  w_data = r_key;
          default: w_data = '0;
        endcase
        // An op is presented only in a cycle the controller is ready, so it is taken exactly once.
        if (bus.cout_ready) begin
          w_op      = state_op(r_state);
          w_state_n = S_CHECK;
        end else begin
          w_state_n = r_state;
        end
      end
      S_CHECK: begin
        if (bus.cout_err != '0) begin
          w_err_n   = bus.cout_err;
          w_state_n = S_REPORT;
        end else begin
          w_state_n = after_check(r_op_st);
        end
      end
      S_START: begin
        if (r_rcnt <= RLENW'(1)) begin
          w_state_n = S_DECIDE;
        end else begin
          w_state_n = S_START;
        end
      end
      S_DECIDE: begin
        if (!bus.cout_ready) begin
          w_bid_n   = bus.cout_maxBid;
          w_state_n = S_DRAIN;
        end else begin
          w_state_n = S_DECIDE;
        end
      end
      S_DRAIN: begin
        if (bus.cout_ready) begin
          w_state_n = S_REPORT;
        end else begin
          w_state_n = S_DRAIN;
        end
      end
      S_REPORT: w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
`ifdef BIDS22_HOST_WATCHDOG_EN
    if ((r_state == S_DECIDE || r_state == S_DRAIN) && (w_state_n == r_state) &&
        (r_wdt >= WDTW'(WDT_CYCLES - 1))) begin
      w_state_n = S_REPORT;
      w_err_n   = HOST_TIMEOUT;
      w_bid_n   = '0;
    end else begin
      w_state_n = w_state_n;
    end
`endif
  end

  // State, job capture, lock tracking and round counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op_st    <= S_IDLE;
      r_armed    <= 1'b0;
      r_locked   <= 1'b0;
      r_lock_key <= '0;
      r_bal      <= '0;
      r_mask     <= '0;
      r_timer    <= '0;
      r_charge   <= '0;
      r_key      <= '0;
      r_rlen     <= '0;
      r_rcnt     <= '0;
      r_err      <= '0;
      r_bid      <= '0;
      r_res_err  <= '0;
      r_res_bid  <= '0;
    end else begin
      r_state <= w_state_n;
      r_armed <= 1'b1;
      r_err   <= w_err_n;
      r_bid   <= w_bid_n;
      if (w_accept) begin
        r_bal    <= bus.job_bal;
        r_mask   <= bus.job_mask;
        r_timer  <= bus.job_timer;
        r_charge <= bus.job_charge;
        r_key    <= bus.job_key;
        r_rlen   <= bus.job_rlen;
      end
      if (w_op != NO_OP) begin
        r_op_st <= r_state;
      end
      if (w_op == LOCK) begin
        r_locked   <= 1'b1;
        r_lock_key <= r_key;
      end else if (r_state == S_CHECK && r_op_st == S_UNLK && bus.cout_err == '0) begin
        r_locked <= 1'b0;
      end
      if (r_state == S_START) begin
        r_rcnt <= r_rcnt - RLENW'(1);
      end else begin
        r_rcnt <= (r_rlen == '0) ? RLENW'(1) : r_rlen;
      end
      if (w_state_n == S_REPORT) begin
        r_res_err <= w_err_n;
        r_res_bid <= w_bid_n;
      end
    end
  end

  assign bus.C_op       = w_op;
  assign bus.C_data     = w_data;
  assign bus.C_start    = (r_state == S_START);
  assign bus.job_ready  = r_armed && (r_state == S_IDLE);
  assign bus.done       = (r_state == S_REPORT);
  assign bus.busy       = (r_state != S_IDLE) && (r_state != S_REPORT);
  assign bus.res_err    = r_res_err;
  assign bus.res_maxbid = r_res_bid;

endmodule

// File: tb/tb_bids22_host_seq.sv
// Directed bench for bids22_host_seq with a small bids22 controller model.
module tb_bids22_host_seq;
  import bids22defs::*;

  localparam int DW = 32;
`ifdef BIDS22_HOST_WATCHDOG_EN
  localparam int TB_WDT = 8;
`else
  localparam int TB_WDT = 64;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bids22_host_seq_if #(.DATAWIDTH(DW), .NUMBIDDERS(3), .RLENW(8)) bus ();

  bids22_host_seq #(.DATAWIDTH(DW), .NUMBIDDERS(3), .RLENW(8), .WDT_CYCLES(TB_WDT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Controller model: one-cycle error after an op, one ready-low decision cycle after a round.
  logic       m_dec, m_started, force_badkey, stall_arm, m_nodrop;
  logic [3:0] m_err;
  int         stall_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_dec <= 1'b0; m_started <= 1'b0; m_err <= 4'd0; stall_cnt <= 0;
    end else begin
      m_err <= (bus.C_op == UNLOCK && force_badkey) ? BADKEY : NOERROR;
      if (bus.C_op == LOADX && stall_arm) stall_cnt <= 4;
      else if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
      m_started <= bus.C_start;
      if (m_dec) m_dec <= 1'b0;
      else if (m_started && !bus.C_start && !m_nodrop) m_dec <= 1'b1;
    end
  end

  assign bus.cout_ready  = !m_dec && (stall_cnt == 0);
  assign bus.cout_err    = m_err;
  assign bus.cout_maxBid = m_dec ? 32'd42 : 32'd0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]  op_q[$];
  logic [31:0] dat_q[$];
  int          cyc_q[$];
  int          cstart_cnt, last_start_cyc;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.C_op != 4'd0) begin
        op_q.push_back(bus.C_op); dat_q.push_back(bus.C_data); cyc_q.push_back(cyc);
      end
      if (bus.C_start) begin
        cstart_cnt = cstart_cnt + 1; last_start_cyc = cyc;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] x, y, z, input logic [2:0] mask,
                           input logic [31:0] tmr, chg, key, input logic [7:0] rlen);
    op_q.delete(); dat_q.delete(); cyc_q.delete(); cstart_cnt = 0; last_start_cyc = 0;
    @(negedge clk);
    bus.job_bal = {z, y, x}; bus.job_mask = mask; bus.job_timer = tmr;
    bus.job_charge = chg; bus.job_key = key; bus.job_rlen = rlen; bus.job_valid = 1'b1;
    for (int n = 0; n < 50 && !bus.job_ready; n++) @(negedge clk);
    check_val("accept_ready", bus.job_ready, 1'b1);
    @(posedge clk); #1;
    bus.job_valid = 1'b0; bus.job_bal = '0; bus.job_mask = '0; bus.job_timer = '0;
    bus.job_charge = '0; bus.job_key = '0; bus.job_rlen = '0;
  endtask

  logic [3:0]  r_err_s;
  logic [31:0] r_bid_s;
  int          done_cyc;

  task automatic wait_done();
    logic got = 1'b0;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1; r_err_s = bus.res_err; r_bid_s = bus.res_maxbid; done_cyc = cyc;
        check_val("busy_at_done", bus.busy, 1'b0);
      end
    end
    check_val("done_seen", got, 1'b1);
    @(negedge clk);
    check_val("done_pulse", bus.done, 1'b0);
    check_val("ready_after", bus.job_ready, 1'b1);
  endtask

  function automatic int count_op(input logic [3:0] op);
    int c = 0;
    foreach (op_q[i]) if (op_q[i] == op) c++;
    return c;
  endfunction

  function automatic int cyc_of(input logic [3:0] op);
    foreach (op_q[i]) if (op_q[i] == op) return cyc_q[i];
    return -1;
  endfunction

  logic [3:0]  e_op[7];
  logic [31:0] e_dat[7];

  initial begin
    bus.job_valid = 1'b0; bus.job_bal = '0; bus.job_mask = '0; bus.job_timer = '0;
    bus.job_charge = '0; bus.job_key = '0; bus.job_rlen = '0;
    force_badkey = 1'b0; stall_arm = 1'b0; m_nodrop = 1'b0;
    cstart_cnt = 0; last_start_cyc = 0;

    repeat (3) @(negedge clk);
    check_val("rst_op", bus.C_op, 4'd0);
    check_val("rst_data", bus.C_data, 32'd0);
    check_val("rst_start", bus.C_start, 1'b0);
    check_val("rst_ready", bus.job_ready, 1'b0);
    check_val("rst_busy", bus.busy, 1'b0);
    check_val("rst_done", bus.done, 1'b0);
    check_val("rst_res", {bus.res_err, bus.res_maxbid}, 36'd0);
    reset = 1'b0;
    #1 check_val("rel_ready0", bus.job_ready, 1'b0);
    @(negedge clk);
    check_val("rel_ready1", bus.job_ready, 1'b1);

    // Job 1: fresh controller, full sequence without UNLOCK
    e_op  = '{LOADX, LOADY, LOADZ, SETMASK, SETTIMER, SETBIDCHARGE, LOCK};
    e_dat = '{32'd100, 32'd200, 32'd300, 32'd7, 32'd15, 32'd1, 32'hA5};
    start_job(32'd100, 32'd200, 32'd300, 3'b111, 32'd15, 32'd1, 32'hA5, 8'd4);
    check_val("j1_busy", bus.busy, 1'b1);
    wait_done();
    check_val("j1_nops", op_q.size(), 7);
    for (int i = 0; i < 7; i++) begin
      check_val($sformatf("j1_op%0d", i), op_q[i], e_op[i]);
      check_val($sformatf("j1_dat%0d", i), dat_q[i], e_dat[i]);
    end
    check_val("j1_cstart", cstart_cnt, 4);
    check_val("j1_err", r_err_s, 4'd0);
    check_val("j1_maxbid", r_bid_s, 32'd42);
    check_val("j1_latency", done_cyc - last_start_cyc, 4);

    // Job 2: UNLOCK with previous key, controller rejects it
    force_badkey = 1'b1;
    start_job(32'd1, 32'd2, 32'd3, 3'b011, 32'd5, 32'd2, 32'h5A, 8'd4);
    wait_done();
    force_badkey = 1'b0;
    check_val("j2_nops", op_q.size(), 1);
    check_val("j2_op0", op_q[0], UNLOCK);
    check_val("j2_dat0", dat_q[0], 32'hA5);
    check_val("j2_cstart", cstart_cnt, 0);
    check_val("j2_err", r_err_s, BADKEY);

    // Job 3: still locked; ready stalls before LOADY; rlen=0
    stall_arm = 1'b1;
    start_job(32'd11, 32'd22, 32'd33, 3'b101, 32'd9, 32'd3, 32'h33, 8'd0);
    wait_done();
    stall_arm = 1'b0;
    check_val("j3_nops", op_q.size(), 8);
    check_val("j3_op0", op_q[0], UNLOCK);
    check_val("j3_dat0", dat_q[0], 32'hA5);
    check_val("j3_loady_cnt", count_op(LOADY), 1);
    check_val("j3_loady_gap", cyc_of(LOADY) - cyc_of(LOADX), 5);
    check_val("j3_cstart", cstart_cnt, 1);
    check_val("j3_err", r_err_s, 4'd0);
    check_val("j3_maxbid", r_bid_s, 32'd42);

    // Job 4: reset while C_start is high
    start_job(32'd7, 32'd8, 32'd9, 3'b110, 32'd4, 32'd1, 32'h77, 8'd10);
    for (int n = 0; n < 200 && !bus.C_start; n++) @(negedge clk);
    check_val("j4_start_seen", bus.C_start, 1'b1);
    check_val("j4_unlock_dat", dat_q[0], 32'h33);
    #2 reset = 1'b1;
    #1;
    check_val("j4_rst_start", bus.C_start, 1'b0);
    check_val("j4_rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Job 5: lock flag cleared by reset -> no UNLOCK
    start_job(32'd5, 32'd6, 32'd7, 3'b001, 32'd2, 32'd1, 32'h11, 8'd2);
    wait_done();
    check_val("j5_nops", op_q.size(), 7);
    check_val("j5_op0", op_q[0], LOADX);
    check_val("j5_cstart", cstart_cnt, 2);
    check_val("j5_err", r_err_s, 4'd0);

`ifdef BIDS22_HOST_WATCHDOG_EN
    // Job 6: controller never drops ready -> watchdog expiry
    m_nodrop = 1'b1;
    start_job(32'd1, 32'd1, 32'd1, 3'b111, 32'd1, 32'd1, 32'h22, 8'd1);
    wait_done();
    m_nodrop = 1'b0;
    check_val("j6_err", r_err_s, HOST_TIMEOUT);
    check_val("j6_maxbid", r_bid_s, 32'd0);
    check_val("j6_latency", done_cyc - last_start_cyc, 9);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
